// File: rtl/data_mem.sv
// data_mem: word-organised data memory, combinational read, synchronous write, async clear
module data_mem #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        writeEnable,
  input  logic [31:0] address,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  input  logic        reset
);
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] idx;
  logic          in_range;
  logic          unused_lsbs;
  assign idx         = address[AW+1:2];
  assign in_range    = address[31:AW+2] == '0;
  assign unused_lsbs = ^address[1:0];
  // Addresses above the array read as zero instead of aliasing onto a real word
  always_comb readData = in_range ? mem_q[idx] : 32'h0;
  // Reset clears every word at once and blocks writes; otherwise one qualified word is written per edge
  always_ff @(posedge clk or posedge reset)
    if (reset) mem_q <= '{default: 32'h0};
    else if (writeEnable && in_range) mem_q[idx] <= writeData;
endmodule

// File: tb/tb_data_mem.sv
// tb_data_mem: directed self-checking bench for data_mem
`timescale 1ns/1ps
module tb_data_mem;
  localparam int DEPTH = 64;
  logic        clk = 0;
  logic        writeEnable = 0;
  logic [31:0] address = 0;
  logic [31:0] writeData = 0;
  logic [31:0] readData;
  logic        reset = 1;
  int          n_checks = 0;
  int          n_fail = 0;

  data_mem #(.DEPTH(DEPTH)) dut (
    .clk(clk), .writeEnable(writeEnable), .address(address),
    .writeData(writeData), .readData(readData), .reset(reset)
  );

  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a;
    writeData = d;
    writeEnable = 1;
    @(posedge clk);
    #1 writeEnable = 0;
  endtask

  task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
    address = a;
    #1 check(tag, readData, exp);
  endtask

  initial begin
    #1 check("reset_state", readData, 32'h0);
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    address = 0; writeData = 32; writeEnable = 1;
    #2 writeEnable = 0;
    @(posedge clk);
    #1 check("en_not_sampled_w0", readData, 32'h0);
    @(negedge clk);
    address = 4; writeData = 99; writeEnable = 1;
    #2 writeEnable = 0;
    @(posedge clk);
    #1 check("en_not_sampled_w1", readData, 32'h0);
    @(negedge clk);
    write(0, 32);
    check("write_w0", readData, 32);
    write(4, 99);
    check("write_w1", readData, 99);
    read_check("w0_kept", 0, 32);
    write(8, 32'hDEADBEEF);
    read_check("misalign_9", 9, 32'hDEADBEEF);
    read_check("misalign_10", 10, 32'hDEADBEEF);
    read_check("misalign_11", 11, 32'hDEADBEEF);
    write(4 * DEPTH, 32'h1234);
    check("oor_read", readData, 32'h0);
    read_check("oor_w0_kept", 0, 32);
    read_check("oor_w1_kept", 4, 99);
    write(32'h8000_0000, 32'h5555);
    check("oor_high_read", readData, 32'h0);
    read_check("oor_high_w0_kept", 0, 32);
    for (int i = 0; i < 4; i++) write(i * 4, i + 1);
    read_check("prefill_w3", 12, 4);
    @(negedge clk);
    #1 reset = 1;
    for (int i = 0; i < 4; i++) read_check($sformatf("async_reset_w%0d", i), i * 4, 32'h0);
    address = 0; writeData = 77; writeEnable = 1;
    @(posedge clk);
    #1 check("we_during_reset_w0", readData, 32'h0);
    @(posedge clk);
    read_check("we_during_reset_w3", 12, 32'h0);
    @(negedge clk);
    writeEnable = 0;
    reset = 0;
    write(12, 32'hA5A5A5A5);
    @(negedge clk);
    address = 12; writeData = 32'h5A5A5A5A; writeEnable = 1;
    #1 check("rdw_before", readData, 32'hA5A5A5A5);
    @(posedge clk);
    #1 check("rdw_after", readData, 32'h5A5A5A5A);
    writeEnable = 0;
    for (int i = 0; i < DEPTH; i++) write(i * 4, i * 3 + 7);
    for (int i = 0; i < DEPTH; i++) read_check($sformatf("sweep_%0d", i), i * 4, i * 3 + 7);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
